// File: rtl/axi4_ar_rr_arbiter_if.sv
// Signal bundle for the two-master AXI4 read arbiter: two requester-side AR/R ports
// and one shared downstream AR/R port. The arbiter uses "slave"; the environment uses "master".
interface axi4_ar_rr_arbiter_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 1,
  parameter int SB_WIDTH   = 16 + USER_WIDTH
);

  logic [1:0]              s_arvalid;
  logic [1:0]              s_arready;
  logic [2*ID_WIDTH-1:0]   s_arid;
  logic [2*ADDR_WIDTH-1:0] s_araddr;
  logic [2*8-1:0]          s_arlen;
  logic [2*3-1:0]          s_arsize;
  logic [2*2-1:0]          s_arburst;
  logic [2*SB_WIDTH-1:0]   s_arsb;

  logic [1:0]              s_rvalid;
  logic [1:0]              s_rready;
  logic [ID_WIDTH-1:0]     s_rid;
  logic [DATA_WIDTH-1:0]   s_rdata;
  logic [1:0]              s_rresp;
  logic                    s_rlast;

  logic                    m_arvalid;
  logic                    m_arready;
  logic [ID_WIDTH:0]       m_arid;
  logic [ADDR_WIDTH-1:0]   m_araddr;
  logic [7:0]              m_arlen;
  logic [2:0]              m_arsize;
  logic [1:0]              m_arburst;
  logic [SB_WIDTH-1:0]     m_arsb;

  logic                    m_rvalid;
  logic                    m_rready;
  logic [ID_WIDTH:0]       m_rid;
  logic [DATA_WIDTH-1:0]   m_rdata;
  logic [1:0]              m_rresp;
  logic                    m_rlast;

  modport slave (
    input  s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arsb,
    output s_arready,
    output s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
    input  s_rready,
    output m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arsb,
    input  m_arready,
    input  m_rvalid, m_rid, m_rdata, m_rresp, m_rlast,
    output m_rready
  );

  modport master (
    output s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arsb,
    input  s_arready,
    input  s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
    output s_rready,
    input  m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arsb,
    output m_arready,
    output m_rvalid, m_rid, m_rdata, m_rresp, m_rlast,
    input  m_rready
  );

endinterface

// File: rtl/axi4_ar_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4 read path between two masters. AR grants are held
// until the downstream handshake; R beats route back by the extended-ID MSB.
module axi4_ar_rr_arbiter #(
  parameter int ID_WIDTH        = 4,
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int USER_WIDTH      = 1,
  parameter int SB_WIDTH        = 16 + USER_WIDTH,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  axi4_ar_rr_arbiter_if.slave   bus,
  output logic                  err_unexp_r
);

  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]            state;
  logic [0:0]            state_nxt;
  logic                  gnt;
  logic                  gnt_nxt;
  logic                  rr_ptr;
  logic [CNT_W-1:0]      cnt [2];
  logic [1:0]            eligible;
  logic [1:0]            cnt_inc;
  logic [1:0]            cnt_dec;

  logic                  m_arvalid;
  logic                  ar_hs;
  logic                  r_own;
  logic                  r_hs;
  logic                  r_last_hs;
  logic                  r_unexp;

  logic [ID_WIDTH-1:0]   sel_arid;
  logic [ADDR_WIDTH-1:0] sel_araddr;
  logic [7:0]            sel_arlen;
  logic [2:0]            sel_arsize;
  logic [1:0]            sel_arburst;
  logic [SB_WIDTH-1:0]   sel_arsb;
  logic [DATA_WIDTH-1:0] r_data;

  // A master already at its outstanding cap sits out arbitration; its R path is unaffected.
  assign eligible[0] = bus.s_arvalid[0] && (cnt[0] < CNT_MAX);
  assign eligible[1] = bus.s_arvalid[1] && (cnt[1] < CNT_MAX);

  assign m_arvalid = (state == ST_GRANT);
  assign ar_hs     = m_arvalid && bus.m_arready;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    case (state)
      ST_IDLE: begin
        if (|eligible) begin
          state_nxt = ST_GRANT;
          gnt_nxt   = (&eligible) ? rr_ptr : eligible[1];
        end
      end
      ST_GRANT: begin
        if (ar_hs) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state  <= ST_IDLE;
      gnt    <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      if (ar_hs) begin
        rr_ptr <= ~gnt;
      end
    end
  end

  // The grant is registered, so the AR mux below is stable for the whole GRANT state.
  always_comb begin
    if (gnt) begin
      sel_arid    = bus.s_arid[2*ID_WIDTH-1:ID_WIDTH];
      sel_araddr  = bus.s_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH];
      sel_arlen   = bus.s_arlen[15:8];
      sel_arsize  = bus.s_arsize[5:3];
      sel_arburst = bus.s_arburst[3:2];
      sel_arsb    = bus.s_arsb[2*SB_WIDTH-1:SB_WIDTH];
    end else begin
      sel_arid    = bus.s_arid[ID_WIDTH-1:0];
      sel_araddr  = bus.s_araddr[ADDR_WIDTH-1:0];
      sel_arlen   = bus.s_arlen[7:0];
      sel_arsize  = bus.s_arsize[2:0];
      sel_arburst = bus.s_arburst[1:0];
      sel_arsb    = bus.s_arsb[SB_WIDTH-1:0];
    end
  end

  assign bus.m_arvalid = m_arvalid;
  assign bus.m_arid    = {gnt, sel_arid};
  assign bus.m_araddr  = sel_araddr;
  assign bus.m_arlen   = sel_arlen;
  assign bus.m_arsize  = sel_arsize;
  assign bus.m_arburst = sel_arburst;
  assign bus.m_arsb    = sel_arsb;
  assign bus.s_arready = m_arvalid ? {gnt & bus.m_arready, ~gnt & bus.m_arready} : 2'b00;

  // R routing is purely combinational; the owner comes from the ID bit added on the AR side.
  assign r_own     = bus.m_rid[ID_WIDTH];
  assign r_data    = bus.m_rdata;
  assign r_hs      = bus.m_rvalid && bus.m_rready;
  assign r_last_hs = r_hs && bus.m_rlast;
  assign r_unexp   = r_hs && (cnt[r_own] == '0);

  assign bus.s_rvalid = areset ? 2'b00 : {r_own & bus.m_rvalid, ~r_own & bus.m_rvalid};
  assign bus.m_rready = ~areset & bus.s_rready[r_own];
  assign bus.s_rid    = bus.m_rid[ID_WIDTH-1:0];
  assign bus.s_rdata  = r_data;
  assign bus.s_rresp  = bus.m_rresp;
  assign bus.s_rlast  = bus.m_rlast;

  // A last beat to a master with nothing outstanding does not decrement (saturate at 0).
  assign cnt_inc[0] = ar_hs && !gnt;
  assign cnt_inc[1] = ar_hs && gnt;
  assign cnt_dec[0] = r_last_hs && !r_own && (cnt[0] != '0);
  assign cnt_dec[1] = r_last_hs && r_own && (cnt[1] != '0);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cnt_inc[i] && !cnt_dec[i]) begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end else if (cnt_dec[i] && !cnt_inc[i]) begin
          cnt[i] <= cnt[i] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_unexp_r <= 1'b0;
    end else begin
      err_unexp_r <= r_unexp;
    end
  end

  a_grant_held: assert property (@(posedge aclk) disable iff (areset)
    (m_arvalid && !bus.m_arready) |=> (m_arvalid && $stable(gnt)));

  a_cnt_bound: assert property (@(posedge aclk) disable iff (areset)
    (cnt[0] <= CNT_MAX) && (cnt[1] <= CNT_MAX));

  a_rvalid_onehot: assert property (@(posedge aclk) disable iff (areset)
    $onehot0(bus.s_rvalid));

endmodule

// File: tb/tb_axi4_ar_rr_arbiter.sv
// Directed bench for axi4_ar_rr_arbiter: R routing vector table plus hand-written AR/counter
// sequences; dut_b runs with a cap of 2 outstanding bursts to exercise the exclusion path.
module tb_axi4_ar_rr_arbiter;

  localparam int ID_WIDTH   = 4;
  localparam int ADDR_WIDTH = 64;
  localparam int DATA_WIDTH = 512;
  localparam int USER_WIDTH = 1;
  localparam int SB_WIDTH   = 16 + USER_WIDTH;

  logic aclk = 1'b0;
  logic areset;
  logic err_a;
  logic err_b;
  int   total = 0;
  int   bad   = 0;

  axi4_ar_rr_arbiter_if #(.ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                          .USER_WIDTH(USER_WIDTH), .SB_WIDTH(SB_WIDTH)) bus_a ();
  axi4_ar_rr_arbiter_if #(.ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                          .USER_WIDTH(USER_WIDTH), .SB_WIDTH(SB_WIDTH)) bus_b ();

  axi4_ar_rr_arbiter #(.ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                       .USER_WIDTH(USER_WIDTH), .SB_WIDTH(SB_WIDTH), .MAX_OUTSTANDING(8)) dut_a (
    .aclk(aclk), .areset(areset), .bus(bus_a), .err_unexp_r(err_a));

  axi4_ar_rr_arbiter #(.ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                       .USER_WIDTH(USER_WIDTH), .SB_WIDTH(SB_WIDTH), .MAX_OUTSTANDING(2)) dut_b (
    .aclk(aclk), .areset(areset), .bus(bus_b), .err_unexp_r(err_b));

  always #5 aclk = ~aclk;

  typedef struct {
    logic        m_rvalid;
    logic [4:0]  m_rid;
    logic [1:0]  s_rready;
    logic [1:0]  m_rresp;
    logic [63:0] m_rdata;
    logic [1:0]  exp_s_rvalid;
    logic        exp_m_rready;
    logic [3:0]  exp_s_rid;
  } r_vec_t;

  r_vec_t r_vecs [7];

  task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_a.s_arvalid = '0; bus_a.s_arid = '0; bus_a.s_araddr = '0; bus_a.s_arlen = '0;
    bus_a.s_arsize = '0; bus_a.s_arburst = '0; bus_a.s_arsb = '0; bus_a.s_rready = '0;
    bus_a.m_arready = 1'b0; bus_a.m_rvalid = 1'b0; bus_a.m_rid = '0; bus_a.m_rdata = '0;
    bus_a.m_rresp = '0; bus_a.m_rlast = 1'b0;
    bus_b.s_arvalid = '0; bus_b.s_arid = '0; bus_b.s_araddr = '0; bus_b.s_arlen = '0;
    bus_b.s_arsize = '0; bus_b.s_arburst = '0; bus_b.s_arsb = '0; bus_b.s_rready = '0;
    bus_b.m_arready = 1'b0; bus_b.m_rvalid = 1'b0; bus_b.m_rid = '0; bus_b.m_rdata = '0;
    bus_b.m_rresp = '0; bus_b.m_rlast = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    areset = 1'b1;
    bus_a.m_rvalid = 1'b1;
    bus_a.m_rid    = 5'h13;
    repeat (2) tick();
    check_output("rst_s_rvalid_gated", 512'(bus_a.s_rvalid), 512'(2'b00));
    bus_a.m_rvalid = 1'b0;
    bus_a.m_rid    = '0;
    areset = 1'b0;
    #1;
  endtask

  task automatic apply_stimulus(input r_vec_t v);
    bus_a.m_rvalid = v.m_rvalid;
    bus_a.m_rid    = v.m_rid;
    bus_a.s_rready = v.s_rready;
    bus_a.m_rresp  = v.m_rresp;
    bus_a.m_rdata  = {8{v.m_rdata}};
    bus_a.m_rlast  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    r_vecs[0] = '{1'b1, 5'h13, 2'b00, 2'b00, 64'h0123_4567_89AB_CDEF, 2'b10, 1'b0, 4'h3};
    r_vecs[1] = '{1'b1, 5'h13, 2'b10, 2'b01, 64'hDEAD_BEEF_0000_0001, 2'b10, 1'b1, 4'h3};
    r_vecs[2] = '{1'b1, 5'h13, 2'b01, 2'b10, 64'h5555_AAAA_5555_AAAA, 2'b10, 1'b0, 4'h3};
    r_vecs[3] = '{1'b1, 5'h07, 2'b01, 2'b11, 64'hFFFF_0000_FFFF_0000, 2'b01, 1'b1, 4'h7};
    r_vecs[4] = '{1'b1, 5'h0E, 2'b10, 2'b00, 64'h1111_2222_3333_4444, 2'b01, 1'b0, 4'hE};
    r_vecs[5] = '{1'b0, 5'h1F, 2'b11, 2'b01, 64'h8000_0000_0000_0001, 2'b00, 1'b1, 4'hF};
    r_vecs[6] = '{1'b0, 5'h00, 2'b00, 2'b00, 64'h0000_0000_0000_0000, 2'b00, 1'b0, 4'h0};

    // Reset state
    do_reset();
    check_output("t1_m_arvalid", 512'(bus_a.m_arvalid), 512'(1'b0));
    check_output("t1_s_arready", 512'(bus_a.s_arready), 512'(2'b00));
    check_output("t1_s_rvalid",  512'(bus_a.s_rvalid),  512'(2'b00));
    check_output("t1_err",       512'(err_a),           512'(1'b0));
    check_output("t1_cnt0",      512'(dut_a.cnt[0]),    512'(0));
    check_output("t1_cnt1",      512'(dut_a.cnt[1]),    512'(0));

    // Master 0 alone
    bus_a.s_arvalid = 2'b01;
    bus_a.s_arid    = {4'h0, 4'h5};
    bus_a.s_araddr  = {64'h0, 64'h1000};
    bus_a.s_arlen   = {8'h00, 8'h07};
    bus_a.m_arready = 1'b1;
    #1;
    check_output("t2_idle_arvalid", 512'(bus_a.m_arvalid), 512'(1'b0));
    tick();
    check_output("t2_arvalid",  512'(bus_a.m_arvalid), 512'(1'b1));
    check_output("t2_arid",     512'(bus_a.m_arid),    512'(5'h05));
    check_output("t2_araddr",   512'(bus_a.m_araddr),  512'(64'h1000));
    check_output("t2_arlen",    512'(bus_a.m_arlen),   512'(8'h07));
    check_output("t2_s_arready", 512'(bus_a.s_arready), 512'(2'b01));
    tick();
    bus_a.s_arvalid = 2'b00;
    #1;
    check_output("t2_s_arready_off", 512'(bus_a.s_arready), 512'(2'b00));
    check_output("t2_cnt0",          512'(dut_a.cnt[0]),    512'(1));
    tick();
    check_output("t2_no_regrant", 512'(bus_a.m_arvalid), 512'(1'b0));

    // Both masters continuously valid: grants alternate starting at 0
    do_reset();
    bus_a.s_arvalid = 2'b11;
    bus_a.s_arid    = {4'hB, 4'hA};
    bus_a.s_araddr  = {64'h2000, 64'h1000};
    bus_a.m_arready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic g;
      g = 1'(k % 2);
      tick();
      check_output($sformatf("t3_arvalid_%0d", k), 512'(bus_a.m_arvalid), 512'(1'b1));
      check_output($sformatf("t3_arid_%0d", k), 512'(bus_a.m_arid), 512'({g, g ? 4'hB : 4'hA}));
      check_output($sformatf("t3_araddr_%0d", k), 512'(bus_a.m_araddr), 512'(g ? 64'h2000 : 64'h1000));
      check_output($sformatf("t3_s_arready_%0d", k), 512'(bus_a.s_arready), 512'(g ? 2'b10 : 2'b01));
      tick();
      check_output($sformatf("t3_bubble_%0d", k), 512'(bus_a.m_arvalid), 512'(1'b0));
    end
    bus_a.s_arvalid = 2'b00;
    check_output("t3_cnt0", 512'(dut_a.cnt[0]), 512'(2));
    check_output("t3_cnt1", 512'(dut_a.cnt[1]), 512'(2));

    // Grant held under downstream backpressure
    bus_a.m_arready = 1'b0;
    bus_a.s_arvalid = 2'b11;
    tick();
    for (int k = 0; k < 3; k++) begin
      check_output($sformatf("t3b_arvalid_%0d", k), 512'(bus_a.m_arvalid), 512'(1'b1));
      check_output($sformatf("t3b_arid_%0d", k), 512'(bus_a.m_arid), 512'(5'h0A));
      check_output($sformatf("t3b_s_arready_%0d", k), 512'(bus_a.s_arready), 512'(2'b00));
      tick();
    end
    bus_a.m_arready = 1'b1;
    #1;
    check_output("t3b_s_arready_go", 512'(bus_a.s_arready), 512'(2'b01));
    tick();
    bus_a.s_arvalid = 2'b00;
    check_output("t3b_cnt0", 512'(dut_a.cnt[0]), 512'(3));

    // R routing vector table (non-last beats, counters untouched)
    for (int i = 0; i < 7; i++) begin
      @(negedge aclk);
      apply_stimulus(r_vecs[i]);
      #1;
      check_output($sformatf("rv%0d_s_rvalid", i), 512'(bus_a.s_rvalid), 512'(r_vecs[i].exp_s_rvalid));
      check_output($sformatf("rv%0d_m_rready", i), 512'(bus_a.m_rready), 512'(r_vecs[i].exp_m_rready));
      check_output($sformatf("rv%0d_s_rid", i), 512'(bus_a.s_rid), 512'(r_vecs[i].exp_s_rid));
      check_output($sformatf("rv%0d_s_rdata", i), bus_a.s_rdata, {8{r_vecs[i].m_rdata}});
      check_output($sformatf("rv%0d_s_rresp", i), 512'(bus_a.s_rresp), 512'(r_vecs[i].m_rresp));
    end
    tick();
    check_output("rv_cnt0_kept", 512'(dut_a.cnt[0]), 512'(3));
    check_output("rv_cnt1_kept", 512'(dut_a.cnt[1]), 512'(2));

    // Routing with backpressure, then the last-beat handshake
    bus_a.m_rvalid = 1'b1;
    bus_a.m_rid    = 5'h13;
    bus_a.m_rlast  = 1'b1;
    bus_a.s_rready = 2'b00;
    #1;
    check_output("t5_s_rvalid", 512'(bus_a.s_rvalid), 512'(2'b10));
    check_output("t5_s_rid",    512'(bus_a.s_rid),    512'(4'h3));
    check_output("t5_m_rready", 512'(bus_a.m_rready), 512'(1'b0));
    check_output("t5_s_rlast",  512'(bus_a.s_rlast),  512'(1'b1));
    tick();
    check_output("t5_cnt1_held", 512'(dut_a.cnt[1]), 512'(2));
    bus_a.s_rready = 2'b10;
    #1;
    check_output("t5_m_rready_up", 512'(bus_a.m_rready), 512'(1'b1));
    tick();
    check_output("t5_cnt1_dec", 512'(dut_a.cnt[1]), 512'(1));
    check_output("t5_err",      512'(err_a),        512'(1'b0));
    bus_a.m_rvalid = 1'b0;
    bus_a.s_rready = 2'b00;

    // Drain master 0, then one unexpected last beat
    bus_a.m_rvalid = 1'b1;
    bus_a.m_rid    = 5'h02;
    bus_a.m_rlast  = 1'b1;
    bus_a.s_rready = 2'b01;
    repeat (3) tick();
    check_output("t6_cnt0_drained", 512'(dut_a.cnt[0]), 512'(0));
    check_output("t6_err_quiet",    512'(err_a),        512'(1'b0));
    tick();
    check_output("t6_err_pulse", 512'(err_a),        512'(1'b1));
    check_output("t6_cnt0_sat",  512'(dut_a.cnt[0]), 512'(0));
    bus_a.m_rvalid = 1'b0;
    bus_a.s_rready = 2'b00;
    tick();
    check_output("t6_err_clear", 512'(err_a), 512'(1'b0));

    // Same-cycle AR issue and R last on master 0
    bus_a.s_arvalid = 2'b01;
    bus_a.m_arready = 1'b1;
    repeat (6) tick();
    bus_a.s_arvalid = 2'b00;
    check_output("t7_cnt0_pre", 512'(dut_a.cnt[0]), 512'(3));
    bus_a.s_arvalid = 2'b01;
    tick();
    check_output("t7_arvalid", 512'(bus_a.m_arvalid), 512'(1'b1));
    bus_a.m_rvalid = 1'b1;
    bus_a.m_rid    = 5'h02;
    bus_a.m_rlast  = 1'b1;
    bus_a.s_rready = 2'b01;
    tick();
    bus_a.s_arvalid = 2'b00;
    bus_a.m_rvalid  = 1'b0;
    check_output("t7_cnt0_same", 512'(dut_a.cnt[0]),   512'(3));
    check_output("t7_arvalid_off", 512'(bus_a.m_arvalid), 512'(1'b0));
    check_output("t7_err",       512'(err_a),          512'(1'b0));

    // Outstanding cap of 2 on dut_b
    bus_b.s_arvalid = 2'b10;
    bus_b.s_arid    = {4'h3, 4'h6};
    bus_b.m_arready = 1'b1;
    repeat (4) tick();
    check_output("t4_cnt1_full", 512'(dut_b.cnt[1]), 512'(2));
    tick();
    check_output("t4_capped_a", 512'(bus_b.m_arvalid), 512'(1'b0));
    tick();
    check_output("t4_capped_b", 512'(bus_b.m_arvalid), 512'(1'b0));
    bus_b.s_arvalid = 2'b11;
    tick();
    check_output("t4_m0_grant", 512'(bus_b.m_arvalid), 512'(1'b1));
    check_output("t4_m0_arid",  512'(bus_b.m_arid),    512'(5'h06));
    tick();
    bus_b.s_arvalid = 2'b10;
    check_output("t4_cnt0", 512'(dut_b.cnt[0]), 512'(1));
    tick();
    check_output("t4_still_capped", 512'(bus_b.m_arvalid), 512'(1'b0));
    bus_b.m_rvalid = 1'b1;
    bus_b.m_rid    = 5'h13;
    bus_b.m_rlast  = 1'b1;
    bus_b.s_rready = 2'b10;
    tick();
    bus_b.m_rvalid = 1'b0;
    check_output("t4_cnt1_dec", 512'(dut_b.cnt[1]),   512'(1));
    check_output("t4_no_grant_yet", 512'(bus_b.m_arvalid), 512'(1'b0));
    tick();
    check_output("t4_m1_grant", 512'(bus_b.m_arvalid), 512'(1'b1));
    check_output("t4_m1_arid",  512'(bus_b.m_arid),    512'(5'h13));
    tick();
    bus_b.s_arvalid = 2'b00;
    check_output("t4_cnt1_back", 512'(dut_b.cnt[1]), 512'(2));
    check_output("t4_err",       512'(err_b),        512'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_ar_rr_arbiter.md
Name: axi4_ar_rr_arbiter

Overview:
Two-requester arbiter that shares one AXI4 read path (AR and R channels) between two masters.
- AR: round-robin arbitration, with the grant held until the downstream handshake completes.
- R: beats are routed back to the owning master by the extended-ID MSB.
- Per-master outstanding-burst counters cap in-flight reads.
- Sits between two read masters (e.g. DMA engines) and a single memory-side AXI4 slave port.

Parameters:
ID_WIDTH, 4, requester-side ARID/RID width; downstream IDs are ID_WIDTH+1 bits.
ADDR_WIDTH, 64, address width.
DATA_WIDTH, 512, read data width.
USER_WIDTH, 1, AUSER width.
SB_WIDTH, 16+USER_WIDTH, packed AR sideband {alock, acache[3:0], aprot[2:0], aqos[3:0], aregion[3:0], auser}.
MAX_OUTSTANDING, 8, max in-flight bursts per master (1..255).

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
s_arvalid  in  2  per-master AR valid, bit i = master i
s_arready  out  2  per-master AR ready
s_arid  in  2*ID_WIDTH  per-master ARID, master i in slice i
s_araddr  in  2*ADDR_WIDTH  per-master address
s_arlen  in  2*8  burst length
s_arsize  in  2*3  burst size
s_arburst  in  2*2  burst type
s_arsb  in  2*SB_WIDTH  packed sideband
s_rvalid  out  2  per-master R valid
s_rready  in  2  per-master R ready
s_rid  out  ID_WIDTH  RID, shared by both masters
s_rdata  out  DATA_WIDTH  read data, shared
s_rresp  out  2  response, shared
s_rlast  out  1  last beat, shared
m_arvalid/m_arready  out/in  1/1  downstream AR handshake
m_arid  out  ID_WIDTH+1  {master index, s_arid}
m_araddr, m_arlen, m_arsize, m_arburst, m_arsb  out  as above  muxed AR fields
m_rvalid/m_rready  in/out  1/1  downstream R handshake
m_rid  in  ID_WIDTH+1  extended RID
m_rdata, m_rresp, m_rlast  in  DATA_WIDTH/2/1  R payload
err_unexp_r  out  1  one-cycle pulse on an R beat to a master with zero outstanding bursts

Behaviour:
Reset
- areset asserted: FSM=IDLE, rr_ptr=0, both counters=0.
- Outputs: m_arvalid=0, s_arready=0, s_rvalid=0, err_unexp_r=0.
- Reset may arrive mid-burst; in-flight state is discarded, with no recovery.

AR FSM: states IDLE and GRANT.
- Eligible(i) = s_arvalid[i] && cnt[i] < MAX_OUTSTANDING.
- IDLE: if any master is eligible, register gnt and go to GRANT.
  - Both eligible: gnt=rr_ptr.
  - Only one eligible: that master wins.
  - m_arvalid is 0 in IDLE.
- GRANT: m_arvalid=1.
  - All m_ar* fields are muxed combinationally from master gnt; m_arid={gnt, s_arid[gnt]}.
  - s_arready[gnt]=m_arready; s_arready[other]=0.
  - On m_arvalid && m_arready: rr_ptr=~gnt, cnt[gnt]++, return to IDLE.
- Latency: first m_arvalid one cycle after s_arvalid. Minimum spacing between AR issues is 2 cycles (IDLE bubble).
- The grant never changes while m_arvalid=1. Masters must hold their AR fields stable while valid (AXI rule); the block does not check this.

R routing (combinational, no added latency)
- Owner r = m_rid[ID_WIDTH].
- s_rvalid[r]=m_rvalid; s_rvalid[other]=0.
- m_rready=s_rready[r].
- s_rid=m_rid[ID_WIDTH-1:0]; s_rdata, s_rresp, s_rlast pass through unchanged.
- Beat handshake m_rvalid && m_rready && m_rlast: cnt[r]--.

Counters
- Same-cycle AR increment and R-last decrement on the same master: counter unchanged.
- Counter saturates at 0 on decrement.
- err_unexp_r=1 for one cycle when an R handshake occurs with cnt[r]==0.
- A master at MAX_OUTSTANDING is excluded from arbitration only. Its R path is unaffected.

Test Plan:
1. After reset: m_arvalid=0, s_arready=2'b00, s_rvalid=2'b00, cnt={0,0}.
2. Master 0 alone, s_arid=4'h5, araddr=0x1000, m_arready held 1:
   - m_arvalid=1 one cycle later with m_arid=5'h05.
   - s_arready[0] pulses once; cnt0=1.
3. Both masters valid continuously, m_arready=1: grants alternate 0,1,0,1 (rr_ptr starts at 0); m_arid MSB toggles on every issue.
4. MAX_OUTSTANDING=2, master 1 issues 2 ARs with no R returned:
   - Master 1 is not granted again; master 0 is still granted.
   - One R beat to rid=5'h13 with rlast=1: cnt1 drops to 1 and master 1 is granted next.
5. Routing and backpressure:
   - R beat with m_rid=5'h13, m_rvalid=1, s_rready[1]=0: s_rvalid=2'b10, s_rid=4'h3, m_rready=0.
   - Raise s_rready[1]: the handshake completes.
6. Unexpected beat: R beat with m_rid=5'h02 while cnt0=0 -> err_unexp_r pulses for 1 cycle; cnt0 stays 0.
7. Same-cycle AR and R-last on master 0 (cnt0=3): cnt0 stays 3.
